// File: rtl/fir_input_sequencer.sv
// Upstream feeder for the FIR controller: buffers host words in a small FIFO and issues
// them one at a time as registered dr (sample) / lc (coefficient) pulses, paced by modwait.
// Also tracks the next coefficient index and latches a sticky sequencing error.
module fir_input_sequencer #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned NUM_COEFF = 4,
    parameter int unsigned TIMEOUT   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_is_coeff,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              modwait,
    output logic              dr,
    output logic              lc,
    output logic [DATA_W-1:0] sample_data,
    output logic [DATA_W-1:0] fir_coeff,
    output logic [1:0]        coeff_num,
    output logic              coeff_set,
    output logic              err_seq
);

    localparam int unsigned PtrW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW    = $clog2(DEPTH + 1);
    localparam int unsigned TmrW    = $clog2(TIMEOUT + 1);
    localparam logic [1:0]  LastIdx = 2'(NUM_COEFF - 1);

    typedef enum logic [1:0] {
        StIdle,
        StWaitAck,
        StWaitDone
    } state_e;

    // FIFO storage: entry = {is_coeff, data}
    logic [DATA_W:0]   mem_q [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]   count_q;

    state_e            state_q, state_d;
    logic [TmrW-1:0]   timer_q, timer_d;
    logic              dr_q, dr_d;
    logic              lc_q, lc_d;
    logic              coeff_set_q, coeff_set_d;
    logic              err_q, err_d;
    logic [1:0]        coeff_num_q, coeff_num_d;
    logic [DATA_W-1:0] sample_q, sample_d;
    logic [DATA_W-1:0] coeff_q, coeff_d;

    logic              full;
    logic              push;
    logic              pop;
    logic [DATA_W:0]   head;
    logic              head_is_coeff;
    logic [DATA_W-1:0] head_data;

    assign full          = (count_q == CntW'(DEPTH));
    assign in_ready      = !full && !rst;
    assign push          = in_valid && in_ready;
    assign head          = mem_q[rd_ptr_q];
    assign head_is_coeff = head[DATA_W];
    assign head_data     = head[DATA_W-1:0];

    // FIFO data write; contents need no reset because count gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_is_coeff, in_data};
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            if (push && !pop) begin
                count_q <= count_q + CntW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CntW'(1);
            end
        end
    end

    // Issue FSM next-state, pop decision and registered-output next values
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        pop         = 1'b0;
        dr_d        = 1'b0;
        lc_d        = 1'b0;
        coeff_set_d = 1'b0;
        err_d       = err_q;
        coeff_num_d = coeff_num_q;
        sample_d    = sample_q;
        coeff_d     = coeff_q;

        unique case (state_q)
            StIdle: begin
                if ((count_q != '0) && !modwait) begin
                    pop = 1'b1;
                    if (head_is_coeff) begin
                        coeff_d     = head_data;
                        lc_d        = 1'b1;
                        coeff_set_d = (coeff_num_q == LastIdx);
                        coeff_num_d = (coeff_num_q == LastIdx) ? 2'd0 : coeff_num_q + 2'd1;
                        timer_d     = TmrW'(1);
                        state_d     = StWaitAck;
                    end else if (coeff_num_q == 2'd0) begin
                        sample_d = head_data;
                        dr_d     = 1'b1;
                        timer_d  = TmrW'(1);
                        state_d  = StWaitAck;
                    end else begin
                        // Sample in the middle of a coefficient set: discard it
                        err_d = 1'b1;
                    end
                end
            end
            StWaitAck: begin
                if (modwait) begin
                    state_d = StWaitDone;
                end else if (timer_q == TmrW'(TIMEOUT)) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    timer_d = timer_q + TmrW'(1);
                end
            end
            StWaitDone: begin
                if (!modwait) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            timer_q     <= '0;
            dr_q        <= 1'b0;
            lc_q        <= 1'b0;
            coeff_set_q <= 1'b0;
            err_q       <= 1'b0;
            coeff_num_q <= 2'd0;
            sample_q    <= '0;
            coeff_q     <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            dr_q        <= dr_d;
            lc_q        <= lc_d;
            coeff_set_q <= coeff_set_d;
            err_q       <= err_d;
            coeff_num_q <= coeff_num_d;
            sample_q    <= sample_d;
            coeff_q     <= coeff_d;
        end
    end

    assign dr          = dr_q;
    assign lc          = lc_q;
    assign coeff_set   = coeff_set_q;
    assign err_seq     = err_q;
    assign coeff_num   = coeff_num_q;
    assign sample_data = sample_q;
    assign fir_coeff   = coeff_q;

endmodule
